float_reciprocal_nr: RTL and testbench
======================================

Name: float_reciprocal_nr

Overview:
Parametrised Newton-Raphson reciprocal for IEEE-754-style floats, successor to the fixed 32-bit SoftMax reciprocal. Generic exponent/mantissa widths, fixed-point mantissa datapath, configurable iteration count and valid/ready handshakes on both sides. Adds special-value handling and exception flags. Feeds the SoftMax normaliser: the 1/sum value multiplies each exponent term.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa width; DATA_W = 1+EXP_W+MAN_W
ITER, 3, Newton iterations after seed (1..7)
GUARD_W, 6, extra fractional bits; FRAC_W = MAN_W+1+GUARD_W

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  block can accept (high only in IDLE)
in_data  in  DATA_W  operand {sign, exp, man}
out_valid  out  1  result valid, held until taken
out_ready  in  1  consumer accepts result
out_data  out  DATA_W  reciprocal
out_flags  out  3  {invalid(NaN in), div_by_zero(zero/denormal in), underflow(flushed to 0)}

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0, all datapath regs 0. Reset mid-operation discards the operation; no output is produced.
- FSM: IDLE -> SEED -> ITER (ITER cycles, counter 0..ITER-1) -> PACK -> HOLD -> IDLE.
- Accept on edge T when in_valid&&in_ready. Operand registered. in_ready drops after edge T.
- Edge T+1 (SEED): D = {1,man} scaled to [0.5,1) in Q0.FRAC_W; X0 = 48/17 - (32/17)*D in Q2.FRAC_W, constants rounded to FRAC_W bits.
- Edges T+2..T+ITER+1: X <= X + X*(1 - D*X). The residual is signed; each product is truncated to FRAC_W fractional bits.
- Edge T+ITER+2 (PACK): out_data and out_flags registered, out_valid=1. Fixed latency ITER+2 cycles, also for special cases.
- HOLD: out_data, out_flags and out_valid stay stable while out_ready=0. On an edge with out_ready=1: out_valid=0, in_ready=1, return to IDLE. A new operand is accepted no earlier than the next edge, so throughput is one result per ITER+4 cycles minimum.
- Exponent rule: e = biased input exponent, B = bias.
  - man==0: result mantissa 0, exponent 2B-e.
  - Otherwise: exponent 2B-1-e, mantissa X[FRAC_W-1 -: MAN_W], truncated.
- Sign of the result = input sign.
- Special cases (priority order):
  - e==all-ones, man!=0: out = canonical quiet NaN (sign 0, exp all-ones, man MSB only); invalid=1.
  - e==all-ones, man==0: out = signed zero.
  - e==0 (zero or denormal; denormals are flushed): out = signed infinity; div_by_zero=1.
  - Computed exponent <=0: out = signed zero; underflow=1.
- Accuracy: with default params, |out - 1/x| <= 1 ulp for all normal x.
- Inputs in_data/in_valid are ignored outside IDLE.

Optional Feature:
Macro: FLOAT_RECIP_EARLY_EXIT_EN
- Defined: during ITER, if the update leaves X unchanged, jump to PACK on the next edge. Latency becomes variable: between 3 and ITER+2 cycles.
- Not defined: always exactly ITER iterations with fixed latency ITER+2; the convergence comparator is not synthesised.
- In both builds, results are bit-identical for the same operand.

Decomposition:
- Shared package float_pkg:
  - state enum
  - flag bit indices
  - functions for bias, field extraction and special-value constants (qNaN, inf, zero) as functions of EXP_W/MAN_W
  - seed constants 48/17 and 32/17 as real-derived localparam functions of FRAC_W
- One sub-module: nr_step (combinational, parametrised by FRAC_W): D, X -> X_next. Instantiated once and shared across iterations.

Test Plan:
- Float32 defaults: 0x40000000 (2.0) -> 0x3F000000, flags 000, out_valid exactly 5 cycles after accept.
- 0xBF000000 (-0.5) -> 0xC0000000; 0x40400000 (3.0) -> 0x3EAAAAAA or 0x3EAAAAAB.
- 0x00000000 -> 0x7F800000 with div_by_zero; 0x80000001 (denormal) -> 0xFF800000 with div_by_zero; 0xFF800000 -> 0x80000000; 0x7FC00001 -> 0x7FC00000 with invalid.
- 0x7F000000 (2^127) -> 0x00000000 with underflow; 0x7E800000 (2^126) -> 0x00800000.
- Hold out_ready=0 for 10 cycles: out_data stable, in_ready=0, extra in_valid ignored. Raise out_ready -> in_ready=1 on the next cycle.
- Assert rst_n=0 during ITER: out_valid stays 0, in_ready=1 immediately. The next operand 0x40800000 returns 0x3E800000.

Source files
------------

// File: rtl/float_pkg.sv
// Shared types, flag indices and format helpers for the Newton-Raphson reciprocal.
// Format helpers take widths as arguments so one package serves any EXP_W/MAN_W.
package float_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_ITER,
    S_PACK,
    S_HOLD
  } state_t;

  localparam int FLAG_INV = 2;
  localparam int FLAG_DBZ = 1;
  localparam int FLAG_UF  = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic fld_sign(input logic [63:0] d, input int exp_w, input int man_w);
    return d[exp_w + man_w];
  endfunction

  function automatic logic [63:0] fld_exp(input logic [63:0] d, input int exp_w, input int man_w);
    return (d >> man_w) & ((64'd1 << exp_w) - 64'd1);
  endfunction

  function automatic logic [63:0] fld_man(input logic [63:0] d, input int man_w);
    return d & ((64'd1 << man_w) - 64'd1);
  endfunction

  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction

  function automatic logic [63:0] inf(input logic s, input int exp_w, input int man_w);
    return ({63'd0, s} << (exp_w + man_w)) | (((64'd1 << exp_w) - 64'd1) << man_w);
  endfunction

  function automatic logic [63:0] zero(input logic s, input int exp_w, input int man_w);
    return {63'd0, s} << (exp_w + man_w);
  endfunction

  // Linear minimax seed for 1/D on [0.5,1): X0 = 48/17 - 32/17*D, both in Q2.frac_w.
  function automatic logic [63:0] seed_c48(input int frac_w);
    real v = 48.0 / 17.0 * (2.0 ** frac_w);
    return 64'(longint'(v));
  endfunction

  function automatic logic [63:0] seed_c32(input int frac_w);
    real v = 32.0 / 17.0 * (2.0 ** frac_w);
    return 64'(longint'(v));
  endfunction

endpackage

// File: rtl/float_reciprocal_nr_step.sv
// One Newton-Raphson reciprocal update: x_next = x + x*(1 - d*x), purely combinational.
// d is Q0.FRAC_W unsigned, x is Q2.FRAC_W unsigned; every product truncates to FRAC_W fraction bits.
module nr_step #(
  parameter int FRAC_W = 30
) (
  input  logic [FRAC_W-1:0] d,
  input  logic [FRAC_W+1:0] x,
  output logic [FRAC_W+1:0] x_next
);

  localparam int XW = FRAC_W + 2;
  localparam int RW = FRAC_W + 3;
  localparam int PW = FRAC_W + XW;
  localparam logic [RW-1:0] ONE = RW'(1) << FRAC_W;

  logic [PW-1:0]   dx;
  logic [XW-1:0]   dx_t;
  logic [RW-1:0]   r;
  logic [2*RW-1:0] xr;

  assign dx   = {{XW{1'b0}}, d} * {{FRAC_W{1'b0}}, x};
  assign dx_t = XW'(dx >> FRAC_W);
  // Residual is signed: the seed may sit on either side of 1/d.
  assign r    = ONE - {1'b0, dx_t};
  assign xr   = {{RW{r[RW-1]}}, r} * {{(RW+1){1'b0}}, x};
  assign x_next = x + XW'(xr >> FRAC_W);

endmodule

// File: rtl/float_reciprocal_nr.sv
// Newton-Raphson float reciprocal with special-value handling; one operand in flight at a time.
// Optional FLOAT_RECIP_EARLY_EXIT_EN: leave the iteration loop as soon as X stops changing.
module float_reciprocal_nr
  import float_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int ITER    = 3,
  parameter int GUARD_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [2:0]             out_flags
);

  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam int FRAC_W = MAN_W + 1 + GUARD_W;
  localparam int XW     = FRAC_W + 2;
  localparam int EW     = EXP_W + 2;

  localparam logic [XW-1:0]    C48   = XW'(seed_c48(FRAC_W));
  localparam logic [XW-1:0]    C32   = XW'(seed_c32(FRAC_W));
  localparam logic [EW-1:0]    TWO_B = EW'(2 * bias(EXP_W));
  localparam logic [EXP_W-1:0] E_MAX = '1;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   op_q;
  logic [FRAC_W-1:0]   d_q;
  logic [XW-1:0]       x_q;
  logic [2:0]          cnt_q;

  logic                op_sign;
  logic [EXP_W-1:0]    op_exp;
  logic [MAN_W-1:0]    op_man;
  logic                man_nz;
  logic [FRAC_W-1:0]   d_seed;
  logic [XW+FRAC_W-1:0] seed_prod;
  logic [XW-1:0]       x_seed;
  logic [XW-1:0]       x_next;
  logic [EW-1:0]       res_exp;
  logic                res_uf;
  logic [MAN_W-1:0]    res_man;
  logic [DATA_W-1:0]   pack_data;
  logic [2:0]          pack_flags;

  assign op_sign = fld_sign(64'(op_q), EXP_W, MAN_W);
  assign op_exp  = EXP_W'(fld_exp(64'(op_q), EXP_W, MAN_W));
  assign op_man  = MAN_W'(fld_man(64'(op_q), MAN_W));
  assign man_nz  = |op_man;

  // {1,man} read as a Q0 fraction lands in [0.5,1).
  assign d_seed    = {1'b1, op_man, {GUARD_W{1'b0}}};
  assign seed_prod = {{FRAC_W{1'b0}}, C32} * {{XW{1'b0}}, d_seed};
  assign x_seed    = C48 - XW'(seed_prod >> FRAC_W);

  nr_step #(.FRAC_W(FRAC_W)) u_step (
    .d      (d_q),
    .x      (x_q),
    .x_next (x_next)
  );

  // X approximates 2/{1.man}; for man==0 it would be exactly 2, so that case bypasses X.
  assign res_exp = TWO_B - {2'b00, op_exp} - {{(EW-1){1'b0}}, man_nz};
  assign res_uf  = res_exp[EW-1] || (res_exp == '0);
  assign res_man = man_nz ? x_q[FRAC_W-1 -: MAN_W] : '0;

  always_comb begin
    pack_data  = {op_sign, res_exp[EXP_W-1:0], res_man};
    pack_flags = '0;
    if (op_exp == E_MAX && man_nz) begin
      pack_data            = DATA_W'(qnan(EXP_W, MAN_W));
      pack_flags[FLAG_INV] = 1'b1;
    end else if (op_exp == E_MAX) begin
      pack_data = DATA_W'(zero(op_sign, EXP_W, MAN_W));
    end else if (op_exp == '0) begin
      pack_data            = DATA_W'(inf(op_sign, EXP_W, MAN_W));
      pack_flags[FLAG_DBZ] = 1'b1;
    end else if (res_uf) begin
      pack_data           = DATA_W'(zero(op_sign, EXP_W, MAN_W));
      pack_flags[FLAG_UF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_SEED;
      end
      S_SEED: state_nxt = S_ITER;
      S_ITER: begin
        if (cnt_q == 3'(ITER - 1)) state_nxt = S_PACK;
`ifdef FLOAT_RECIP_EARLY_EXIT_EN
        else if (x_next == x_q) state_nxt = S_PACK;
`endif
      end
      S_PACK: state_nxt = S_HOLD;
      S_HOLD: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      d_q       <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_flags <= '0;
      out_valid <= 1'b0;
    end else begin
      if (state == S_IDLE && in_valid) op_q <= in_data;
      if (state == S_SEED) begin
        d_q   <= d_seed;
        x_q   <= x_seed;
        cnt_q <= '0;
      end
      if (state == S_ITER) begin
        x_q   <= x_next;
        cnt_q <= cnt_q + 3'd1;
      end
      if (state == S_PACK) begin
        out_data  <= pack_data;
        out_flags <= pack_flags;
        out_valid <= 1'b1;
      end
      if (state == S_HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_float_reciprocal_nr.sv
// Directed bench for float_reciprocal_nr with float32 defaults and hand-computed results.
module tb_float_reciprocal_nr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  int errors = 0;
  int checks = 0;

  float_reciprocal_nr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required finish before 200000", $time);
    $fatal(1, "watchdog");
  end

  // Presents one operand from IDLE and waits (bounded) for out_valid; optionally takes the result.
  task automatic run_op(input logic [31:0] opnd, input bit take,
                        output logic [31:0] res, output logic [2:0] flg, output int lat);
    lat = 0;
    @(negedge clk);
    in_data  = opnd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%08h: out_valid=%0b after %0d cycles, required 1", opnd, out_valid, lat);
    end
    res = out_data;
    flg = out_flags;
    if (take) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %08h want 00000000", out_data); end
    checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL reset_out_flags: got %03b want 000", out_flags); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    @(negedge clk);
    in_data  = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL accept_in_ready_drop: got %0b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_data;
    flg = out_flags;
    checks++; if (lat !== 5) begin errors++; $display("FAIL latency_2p0: got %0d want 5", lat); end
    checks++; if (res !== 32'h3F000000) begin errors++; $display("FAIL data_2p0: got %08h want 3F000000", res); end
    checks++; if (flg !== 3'b000) begin errors++; $display("FAIL flags_2p0: got %03b want 000", flg); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_vectors();
    logic [31:0] vin  [10] = '{32'hBF000000, 32'h40400000, 32'h40A00000, 32'h3FFFFFFF, 32'h00000000,
                               32'h80000001, 32'hFF800000, 32'h7FC00001, 32'h7F000000, 32'h7E800000};
    logic [31:0] vout [10] = '{32'hC0000000, 32'h3EAAAAAA, 32'h3E4CCCCC, 32'h3F000000, 32'h7F800000,
                               32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000, 32'h00800000};
    logic [31:0] valt [10] = '{32'hC0000000, 32'h3EAAAAAB, 32'h3E4CCCCD, 32'h3F000001, 32'h7F800000,
                               32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000, 32'h00800000};
    logic [2:0]  vflg [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b010,
                               3'b010, 3'b000, 3'b100, 3'b001, 3'b000};
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      run_op(vin[i], 1'b1, res, flg, lat);
      checks++;
      if (res !== vout[i] && res !== valt[i]) begin
        errors++;
        $display("FAIL vec_data[%08h]: got %08h want %08h or %08h", vin[i], res, vout[i], valt[i]);
      end
      checks++;
      if (flg !== vflg[i]) begin
        errors++;
        $display("FAIL vec_flags[%08h]: got %03b want %03b", vin[i], flg, vflg[i]);
      end
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL vec_latency[%08h]: got %0d want 5", vin[i], lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    run_op(32'h3F800000, 1'b0, res, flg, lat);
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL hold_data_1p0: got %08h want 3F800000", res); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_data  = 32'h40000000;
      in_valid = 1'b1;
      checks++;
      if (out_data !== 32'h3F800000 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable cycle %0d: data=%08h valid=%0b want 3F800000 valid 1", c, out_data, out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_in_ready cycle %0d: got %0b want 0", c, in_ready);
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_out_valid: got %0b want 0", out_valid); end
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_no_spurious: out_valid=%0b want 0", out_valid); end
    run_op(32'h40400000, 1'b1, res, flg, lat);
    checks++;
    if (res !== 32'h3EAAAAAA && res !== 32'h3EAAAAAB) begin
      errors++;
      $display("FAIL after_hold_3p0: got %08h want 3EAAAAAA or 3EAAAAAB", res);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    @(negedge clk);
    in_data  = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %0b want 0", out_valid); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_no_output: out_valid=%0b want 0", out_valid); end
    run_op(32'h40800000, 1'b1, res, flg, lat);
    checks++; if (res !== 32'h3E800000) begin errors++; $display("FAIL after_reset_4p0: got %08h want 3E800000", res); end
    checks++; if (flg !== 3'b000) begin errors++; $display("FAIL after_reset_flags: got %03b want 000", flg); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
